// File: rtl/bram_sdp_arbiter.sv
// Two-client arbiter in front of one simple-dual-port BRAM: independent round-robin
// read and write channels, with read data steered back to the issuing client.
module bram_sdp_arbiter #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_rreq,
    input  logic [AWIDTH-1:0] a_raddr,
    output logic              a_rgnt,
    output logic              a_rvalid,
    output logic [DWIDTH-1:0] a_rdata,
    input  logic              a_wreq,
    input  logic [AWIDTH-1:0] a_waddr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic              a_wgnt,

    input  logic              b_rreq,
    input  logic [AWIDTH-1:0] b_raddr,
    output logic              b_rgnt,
    output logic              b_rvalid,
    output logic [DWIDTH-1:0] b_rdata,
    input  logic              b_wreq,
    input  logic [AWIDTH-1:0] b_waddr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              b_wgnt,

    output logic              rce,
    output logic [AWIDTH-1:0] ra,
    input  logic [DWIDTH-1:0] rq,
    output logic              wce,
    output logic [AWIDTH-1:0] wa,
    output logic [DWIDTH-1:0] wd
);

    typedef enum logic {
        ID_A = 1'b0,
        ID_B = 1'b1
    } client_e;

    client_e r_rd_ptr;
    client_e r_wr_ptr;
    client_e r_rtag;
    logic    r_rtag_v;

    logic w_a_rgnt, w_b_rgnt, w_a_wgnt, w_b_wgnt;

    // Grants are qualified with rst_n so nothing reaches the BRAM while reset is held.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_a_rgnt = 1'b0;
        w_b_rgnt = 1'b0;
        w_a_wgnt = 1'b0;
        w_b_wgnt = 1'b0;
        if (rst_n) begin
            w_a_rgnt = a_rreq && (!b_rreq || r_rd_ptr == ID_A);
            w_b_rgnt = b_rreq && (!a_rreq || r_rd_ptr == ID_B);
            w_a_wgnt = a_wreq && (!b_wreq || r_wr_ptr == ID_A);
            w_b_wgnt = b_wreq && (!a_wreq || r_wr_ptr == ID_B);
        end
    end

    always_comb begin
        ra = '0;
        wa = '0;
        wd = '0;
        if (w_a_rgnt) begin
            ra = a_raddr;
        end else if (w_b_rgnt) begin
            ra = b_raddr;
        end
        if (w_a_wgnt) begin
            wa = a_waddr;
            wd = a_wdata;
        end else if (w_b_wgnt) begin
            wa = b_waddr;
            wd = b_wdata;
        end
    end

    assign a_rgnt = w_a_rgnt;
    assign b_rgnt = w_b_rgnt;
    assign a_wgnt = w_a_wgnt;
    assign b_wgnt = w_b_wgnt;
    assign rce    = w_a_rgnt | w_b_rgnt;
    assign wce    = w_a_wgnt | w_b_wgnt;

    // Each pointer moves to the client that lost, and holds when its channel is idle.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= ID_A;
            r_wr_ptr <= ID_A;
            r_rtag_v <= 1'b0;
            r_rtag   <= ID_A;
        end else begin
            if (w_a_rgnt) begin
                r_rd_ptr <= ID_B;
                r_rtag_v <= 1'b1;
                r_rtag   <= ID_A;
            end else if (w_b_rgnt) begin
                r_rd_ptr <= ID_A;
                r_rtag_v <= 1'b1;
                r_rtag   <= ID_B;
            end else begin
                r_rtag_v <= 1'b0;
            end

            if (w_a_wgnt) begin
                r_wr_ptr <= ID_B;
            end else if (w_b_wgnt) begin
                r_wr_ptr <= ID_A;
            end
        end
    end

    // rq is valid the cycle after rce, which lines up with the registered tag.
    assign a_rvalid = r_rtag_v && (r_rtag == ID_A);
    assign b_rvalid = r_rtag_v && (r_rtag == ID_B);
    assign a_rdata  = a_rvalid ? rq : '0;
    assign b_rdata  = b_rvalid ? rq : '0;

endmodule

// File: doc/bram_sdp_arbiter.md
Name: bram_sdp_arbiter

Overview:
- Shares one simple-dual-port BRAM between two requesters, A and B.
- BRAM interface: one write port, one registered read port with 1-cycle latency and read enable; holds contents with no reset.
- Read and write channels are arbitrated independently, each with its own round-robin pointer.
- Returns read data to the requester that issued the read, tagged, one cycle after grant.
- Sits between DMA/CPU-side clients and the BRAM instance.

Parameters:
- AWIDTH, 9, BRAM address width (depth = 2^AWIDTH).
- DWIDTH, 32, BRAM data width.

Ports:
- clk  input  1  single clock for arbiter and BRAM.
- rst_n  input  1  asynchronous, active-low reset.
- a_rreq  input  1  A read request; held until a_rgnt.
- a_raddr  input  AWIDTH  A read address.
- a_rgnt  output  1  A read accepted this cycle.
- a_rvalid  output  1  A read data valid.
- a_rdata  output  DWIDTH  A read data.
- a_wreq  input  1  A write request; held until a_wgnt.
- a_waddr  input  AWIDTH  A write address.
- a_wdata  input  DWIDTH  A write data.
- a_wgnt  output  1  A write accepted this cycle.
- b_*  —  —  B client; same set as a_* with identical meaning.
- rce  output  1  BRAM read enable.
- ra  output  AWIDTH  BRAM read address.
- rq  input  DWIDTH  BRAM read data, valid the cycle after rce.
- wce  output  1  BRAM write enable.
- wa  output  AWIDTH  BRAM write address.
- wd  output  DWIDTH  BRAM write data.

Behaviour:
- Reset (rst_n low, async):
  - rd_ptr=A, wr_ptr=A, rtag_v=0, rtag=0.
  - a_rvalid=b_rvalid=0; a_rdata=b_rdata=0.
  - All grants and rce/wce are forced 0 while rst_n is low.
- Grants, rce, ra, wce, wa, wd are combinational from requests and pointers. Each cycle, each channel grants at most one requester.
- Read arbitration:
  - Only one requester: grant it.
  - Both requesting: grant the requester selected by rd_ptr.
  - rce = a_rgnt|b_rgnt; ra = granted address.
  - When there are no requests, ra=0.
- Read pointer update: on any read grant, rd_ptr <= the non-granted requester. With no grant, rd_ptr holds.
- Write arbitration: identical scheme using wr_ptr and wce/wa/wd; wa=0 and wd=0 when idle.
- Read return:
  - On a read grant, register rtag_v<=1 and rtag<=granted id; otherwise rtag_v<=0.
  - a_rvalid = rtag_v && rtag==A; b_rvalid likewise for B.
  - a_rdata = rq when a_rvalid, else 0; b_rdata likewise.
  - Latency is exactly 1 cycle from grant to rvalid.
- Throughput: one read and one write per cycle, sustained.
- Alternation: with both requesters continuously requesting, grants alternate A,B,A,B from reset.
- Same-address read and write in one cycle: read-first. The read returns the old contents; no forwarding.
- Two writes in the same cycle are impossible (single winner), so there is no write collision.
- Request dropped before grant: this is legal; the request is simply withdrawn.
- Address/data stability: requesters keep addr/data stable while req is high and not yet granted.
- Reset mid-operation: a read granted in the cycle before reset assertion produces no rvalid. Memory contents are untouched by reset.
- Pointers are 1-bit each and never exceed two states.

Test Plan:
- Single writer: A writes 0xDEADBEEF to 0x005 → a_wgnt=1 the same cycle, wce=1, wa=0x005. Then A reads 0x005 → a_rvalid=1 one cycle after a_rgnt, a_rdata=0xDEADBEEF, b_rvalid=0.
- Contention:
  - Stimulus: A and B read addresses 0x010/0x020 continuously for 4 cycles from reset; memory preloaded with 0x10/0x20.
  - Grants: A,B,A,B.
  - Returns: a_rvalid/b_rvalid alternate one cycle later with 0x10/0x20.
- Concurrent channels: A writes 0x7 ← 0x11 while B reads 0x7 (old 0x0) in the same cycle → wce and rce both 1; b_rdata=0x0. B reads 0x7 next cycle → 0x11.
- Write fairness: both write 0x1 with A=0xAA, B=0xBB on two consecutive cycles from reset → A then B granted; a following read returns 0xBB.
- Reset mid-read: assert rst_n=0 in the cycle after a_rgnt → a_rvalid stays 0, pointers return to A. After release, A and B contend → A granted first.
